// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: asserts all channel resets at once, releases them in order, channel 0 first.
// Optional RESET_SEQ_CAUSE_EN adds a last_cause register (01 power-on, 10 external, 11 soft).
module reset_sequencer #(
    parameter int CHANNELS      = 4,
    parameter int BITS          = 8,
    parameter int STAGGER_BITS  = 4,
    parameter int DEBOUNCE_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                external_reset,
    input  logic                soft_reset,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready,
    output logic [1:0]          last_cause
);

    // state   | meaning
    // HOLD    | filtered external reset asserted, all channels held
    // POR     | power-on hold count before channel 0 release
    // STAGGER | gap count between successive channel releases
    // RUN     | all channels released, ready
    typedef enum logic [1:0] {HOLD, POR, STAGGER, RUN} state_t;

    localparam int CNT_W = (BITS > STAGGER_BITS) ? BITS : STAGGER_BITS;
    localparam logic [CNT_W-1:0] POR_TC = CNT_W'((1 << BITS) - 1);
    localparam logic [CNT_W-1:0] STG_TC = CNT_W'((1 << STAGGER_BITS) - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CHANNELS-1:0]   rst_out_q, rst_out_d;
    logic                  ready_q, ready_d;

    logic                      ext_meta, ext_sync, ext_filt;
    logic [DEBOUNCE_BITS-1:0]  deb_cnt;
    logic                      ext_req;

    // Button is active-low; the filtered level idles high (no request).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_meta <= 1'b1;
            ext_sync <= 1'b1;
            ext_filt <= 1'b1;
            deb_cnt  <= '0;
        end else begin
            ext_meta <= external_reset;
            ext_sync <= ext_meta;
            if (ext_sync != ext_filt) begin
                if (deb_cnt == '1) begin
                    ext_filt <= ext_sync;
                    deb_cnt  <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign ext_req = ~ext_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= POR;
            cnt_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    // Releases shift the thermometer down one channel; an empty vector means all released.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        if (ext_req) begin
            state_d   = HOLD;
            cnt_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d   = POR;
                    cnt_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                end
                POR, STAGGER: begin
                    if (cnt_q == ((state_q == POR) ? POR_TC : STG_TC)) begin
                        cnt_d     = '0;
                        rst_out_d = rst_out_q << 1;
                        if (rst_out_d == '0) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = STAGGER;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (soft_reset) begin
                        state_d   = POR;
                        cnt_d     = '0;
                        rst_out_d = '1;
                        ready_d   = 1'b0;
                    end
                end
                default: begin
                    state_d   = POR;
                    cnt_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;

`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] cause_q;

    // Leaving HOLD into POR keeps the external cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q <= 2'b01;
        end else if (state_d == HOLD && state_q != HOLD) begin
            cause_q <= 2'b10;
        end else if (state_q == RUN && state_d == POR) begin
            cause_q <= 2'b11;
        end
    end

    assign last_cause = cause_q;
`else
    assign last_cause = 2'b00;
`endif

endmodule
